// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: ALU opcodes, id_ctrl bit layout,
// the ID/EX latch record and its bubble value.
package cpu_pkg;

   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;
   localparam logic [3:0] ALUC_ADD  = 4'b0010;
   localparam logic [3:0] ALUC_SUB  = 4'b0011;
   localparam logic [3:0] ALUC_AND  = 4'b0100;
   localparam logic [3:0] ALUC_OR   = 4'b0101;
   localparam logic [3:0] ALUC_XOR  = 4'b0110;
   localparam logic [3:0] ALUC_NOR  = 4'b0111;
   localparam logic [3:0] ALUC_LUI  = 4'b1000;  // 100x
   localparam logic [3:0] ALUC_SLTU = 4'b1010;
   localparam logic [3:0] ALUC_SLT  = 4'b1011;
   localparam logic [3:0] ALUC_SLL  = 4'b1100;  // shifts occupy 11xx
   localparam logic [3:0] ALUC_SRL  = 4'b1101;
   localparam logic [3:0] ALUC_SRA  = 4'b1110;

   localparam int CTRL_ALU_SRC_IMM   = 0;
   localparam int CTRL_ALU_SRC_SHAMT = 1;
   localparam int CTRL_REG_WRITE     = 2;
   localparam int CTRL_MEM_READ      = 3;
   localparam int CTRL_MEM_WRITE     = 4;
   localparam int CTRL_WB_SEL_LSB    = 5;  // wb_sel occupies bits 7:5

   typedef struct packed {
      logic        valid;
      logic [7:0]  ctrl;
      logic [3:0]  aluc;
      logic [4:0]  shamt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
   } ex_entry_t;

   // All-zero entry: invalid, no control side effects, aluc = ADDU.
   localparam ex_entry_t EX_BUBBLE = '0;

   // True when a nonzero destination is read by the instruction in ID.
   function automatic logic raw_match(input logic [4:0] rd,
                                      input logic [4:0] rs, input logic uses_rs,
                                      input logic [4:0] rt, input logic uses_rt);
      return (rd != 5'd0) && ((rd == rs && uses_rs) || (rd == rt && uses_rt));
   endfunction

endpackage

// File: rtl/ex_fwd_sel.sv
// Three-way operand forward select: EX/MEM beats MEM/WB, register 0 is never
// forwarded.
module ex_fwd_sel (
   input  logic [4:0]  reg_num,
   input  logic [31:0] latched_val,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic [31:0] mem_fwd_val,
   input  logic [4:0]  wb_rd,
   input  logic        wb_reg_write,
   input  logic [31:0] wb_val,
   output logic [31:0] operand
);

   always_comb begin
      operand = latched_val;
      if (reg_num != 5'd0) begin
         if (mem_reg_write && mem_rd == reg_num)
            operand = mem_fwd_val;
         else if (wb_reg_write && wb_rd == reg_num)
            operand = wb_val;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with load-use bubble insertion and ALU operand selection.
// Macro EX_FWD_EN enables the EX/MEM and MEM/WB forward muxes.
module ex_operand_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [31:0] id_rs_val,
   input  logic [31:0] id_rt_val,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic [3:0]  id_aluc,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [7:0]  id_ctrl,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic [31:0] mem_fwd_val,
   input  logic [4:0]  wb_rd,
   input  logic        wb_reg_write,
   input  logic [31:0] wb_val,
   output logic        stall_req,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_aluc,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic [7:0]  ex_ctrl,
   output logic        ex_valid
);

   ex_entry_t ex_reg;
   ex_entry_t ex_next;
   logic      load_use;

   always_comb begin
      ex_next        = EX_BUBBLE;
      ex_next.valid  = id_valid;
      ex_next.ctrl   = id_ctrl;
      ex_next.aluc   = id_aluc;
      ex_next.shamt  = id_shamt;
      ex_next.rs     = id_rs;
      ex_next.rt     = id_rt;
      ex_next.rd     = id_rd;
      ex_next.imm    = id_imm;
      ex_next.rs_val = id_rs_val;
      ex_next.rt_val = id_rt_val;
   end

   assign load_use = ex_reg.valid && ex_reg.ctrl[CTRL_MEM_READ] &&
                     raw_match(ex_reg.rd, id_rs, id_uses_rs, id_rt, id_uses_rt);

`ifdef EX_FWD_EN
   assign stall_req = load_use;
`else
   // Without forwarding every in-flight RAW producer must drain first.
   assign stall_req = load_use ||
      (ex_reg.valid && ex_reg.ctrl[CTRL_REG_WRITE] &&
       raw_match(ex_reg.rd, id_rs, id_uses_rs, id_rt, id_uses_rt)) ||
      (mem_reg_write && raw_match(mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt)) ||
      (wb_reg_write && raw_match(wb_rd, id_rs, id_uses_rs, id_rt, id_uses_rt));
`endif

   always_ff @(posedge clk) begin
      if (rst)
         ex_reg <= EX_BUBBLE;
      else if (flush)
         ex_reg <= EX_BUBBLE;
      else if (stall)
         ex_reg <= ex_reg;
      else if (stall_req)
         ex_reg <= EX_BUBBLE;
      else
         ex_reg <= ex_next;
   end

   // Index 0 is the rs operand, index 1 the rt operand.
   logic [31:0] src_val [2];
   logic [31:0] fwd_val [2];

   assign src_val[0] = ex_reg.rs_val;
   assign src_val[1] = ex_reg.rt_val;

`ifdef EX_FWD_EN
   logic [4:0] src_num [2];
   assign src_num[0] = ex_reg.rs;
   assign src_num[1] = ex_reg.rt;
`else
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{mem_fwd_val, wb_val, ex_reg.rs, ex_reg.rt};
`endif

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
`ifdef EX_FWD_EN
         ex_fwd_sel u_fwd_sel (
            .reg_num       (src_num[gi]),
            .latched_val   (src_val[gi]),
            .mem_rd        (mem_rd),
            .mem_reg_write (mem_reg_write),
            .mem_fwd_val   (mem_fwd_val),
            .wb_rd         (wb_rd),
            .wb_reg_write  (wb_reg_write),
            .wb_val        (wb_val),
            .operand       (fwd_val[gi])
         );
`else
         assign fwd_val[gi] = src_val[gi];
`endif
      end
   endgenerate

   assign alu_a         = ex_reg.ctrl[CTRL_ALU_SRC_SHAMT] ? {27'b0, ex_reg.shamt} : fwd_val[0];
   assign alu_b         = ex_reg.ctrl[CTRL_ALU_SRC_IMM] ? ex_reg.imm : fwd_val[1];
   assign alu_aluc      = ex_reg.aluc;
   assign ex_store_data = fwd_val[1];
   assign ex_rd         = ex_reg.rd;
   assign ex_ctrl       = ex_reg.ctrl;
   assign ex_valid      = ex_reg.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus hand sequences for
// load-use, reset-during-stall and the EX_FWD_EN-dependent behaviour.
module tb_ex_operand_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic [4:0]  id_shamt;
   logic [3:0]  id_aluc;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [7:0]  id_ctrl;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [31:0] mem_fwd_val;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic [31:0] wb_val;
   logic        stall_req;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_aluc;
   logic [4:0]  ex_rd;
   logic [7:0]  ex_ctrl;
   logic        ex_valid;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_aluc(id_aluc), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_ctrl(id_ctrl), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .mem_fwd_val(mem_fwd_val), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .wb_val(wb_val), .stall_req(stall_req), .alu_a(alu_a), .alu_b(alu_b),
      .alu_aluc(alu_aluc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_ctrl(ex_ctrl), .ex_valid(ex_valid)
   );

   localparam logic [7:0] C_ALU   = 8'h04;  // reg_write
   localparam logic [7:0] C_IMM   = 8'h05;  // alu_src_imm | reg_write
   localparam logic [7:0] C_SHAMT = 8'h06;  // alu_src_shamt | reg_write
   localparam logic [7:0] C_LW    = 8'h2D;  // imm | reg_write | mem_read, wb_sel=1

   typedef struct packed {
      logic        stall, flush, valid;
      logic [4:0]  rs;  logic [31:0] rs_val;
      logic [4:0]  rt;  logic [31:0] rt_val;
      logic [31:0] imm; logic [4:0]  shamt; logic [3:0] aluc; logic [4:0] rd;
      logic        uses_rs, uses_rt; logic [7:0] ctrl;
      logic [31:0] e_a, e_b, e_store; logic [3:0] e_aluc; logic [4:0] e_rd;
      logic [7:0]  e_ctrl; logic e_valid, e_sreq;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rs_v,
                         input logic [4:0] rt, input logic [31:0] rt_v,
                         input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] op,
                         input logic [4:0] rd, input logic urs, input logic urt,
                         input logic [7:0] ctrl);
      id_valid = v;  id_rs = rs;  id_rs_val = rs_v;  id_rt = rt;  id_rt_val = rt_v;
      id_imm = imm;  id_shamt = sh;  id_aluc = op;  id_rd = rd;
      id_uses_rs = urs;  id_uses_rt = urt;  id_ctrl = ctrl;
   endtask

   task automatic set_fwd(input logic [4:0] mrd, input logic mwe, input logic [31:0] mval,
                          input logic [4:0] wrd, input logic wwe, input logic [31:0] wval);
      mem_rd = mrd;  mem_reg_write = mwe;  mem_fwd_val = mval;
      wb_rd = wrd;   wb_reg_write = wwe;   wb_val = wval;
   endtask

   vec_t vecs [9];

   initial begin
      // stall flush valid | rs rs_val | rt rt_val | imm shamt aluc rd urs urt ctrl
      //   | exp a, b, store, aluc, rd, ctrl, valid, stall_req
      vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd8, 32'd5, 5'd9, 32'd7, 32'd0, 5'd0, ALUC_ADD, 5'd10, 1'b1, 1'b1, C_ALU,
                  32'd5, 32'd7, 32'd7, ALUC_ADD, 5'd10, C_ALU, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 5'd9, 32'd1, 32'd0, 5'd3, ALUC_SLL, 5'd11, 1'b0, 1'b1, C_SHAMT,
                  32'd3, 32'd1, 32'd1, ALUC_SLL, 5'd11, C_SHAMT, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd8, 32'h10, 5'd12, 32'h99, 32'h0000FFFF, 5'd0, ALUC_OR, 5'd12, 1'b1, 1'b0, C_IMM,
                  32'h10, 32'h0000FFFF, 32'h99, ALUC_OR, 5'd12, C_IMM, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd1, 32'h111, 5'd2, 32'h222, 32'd0, 5'd0, ALUC_SUB, 5'd3, 1'b1, 1'b1, C_ALU,
                  32'h10, 32'h0000FFFF, 32'h99, ALUC_OR, 5'd12, C_IMM, 1'b1, 1'b0};
      vecs[4] = vecs[3];
      vecs[5] = vecs[3];
      vecs[6] = '{1'b1, 1'b1, 1'b1, 5'd1, 32'h111, 5'd2, 32'h222, 32'd0, 5'd0, ALUC_SUB, 5'd3, 1'b1, 1'b1, C_ALU,
                  32'd0, 32'd0, 32'd0, ALUC_ADDU, 5'd0, 8'h00, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd1, 32'h111, 5'd2, 32'h222, 32'd0, 5'd0, ALUC_SUB, 5'd3, 1'b1, 1'b1, C_ALU,
                  32'd0, 32'd0, 32'd0, ALUC_ADDU, 5'd0, 8'h00, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 5'd1, 32'h100, 5'd4, 32'h0, 32'd4, 5'd0, ALUC_ADDU, 5'd4, 1'b1, 1'b0, C_LW,
                  32'h100, 32'd4, 32'd0, ALUC_ADDU, 5'd4, C_LW, 1'b1, 1'b0};

      // Reset
      rst = 1'b1;  stall = 1'b0;  flush = 1'b0;
      set_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 8'd0);
      set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
      tick();
      tick();
      chk("reset alu_a", alu_a, 32'd0);
      chk("reset alu_b", alu_b, 32'd0);
      chk("reset alu_aluc", {28'd0, alu_aluc}, 32'd0);
      chk("reset ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
      chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("reset stall_req", {31'd0, stall_req}, 32'd0);
      chk("reset ex_store_data", ex_store_data, 32'd0);
      $display("reset: alu_a=%h alu_b=%h aluc=%h valid=%b", alu_a, alu_b, alu_aluc, ex_valid);
      rst = 1'b0;

      // Table: ADD, SLL, ORI, three stall cycles, stall+flush, flush, LW
      for (int i = 0; i < 9; i++) begin
         stall = vecs[i].stall;
         flush = vecs[i].flush;
         set_id(vecs[i].valid, vecs[i].rs, vecs[i].rs_val, vecs[i].rt, vecs[i].rt_val,
                vecs[i].imm, vecs[i].shamt, vecs[i].aluc, vecs[i].rd,
                vecs[i].uses_rs, vecs[i].uses_rt, vecs[i].ctrl);
         tick();
         chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].e_a);
         chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].e_b);
         chk($sformatf("vec%0d store", i), ex_store_data, vecs[i].e_store);
         chk($sformatf("vec%0d aluc", i), {28'd0, alu_aluc}, {28'd0, vecs[i].e_aluc});
         chk($sformatf("vec%0d ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
         chk($sformatf("vec%0d ex_ctrl", i), {24'd0, ex_ctrl}, {24'd0, vecs[i].e_ctrl});
         chk($sformatf("vec%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d stall_req", i), {31'd0, stall_req}, {31'd0, vecs[i].e_sreq});
         $display("vec%0d: stall=%b flush=%b -> alu_a=%h alu_b=%h aluc=%h rd=%0d valid=%b",
                  i, stall, flush, alu_a, alu_b, alu_aluc, ex_rd, ex_valid);
      end
      stall = 1'b0;
      flush = 1'b0;

      // Load-use: LW rd=4 sits in EX; ADDU in ID reads r4
      set_id(1'b1, 5'd4, 32'h44, 5'd5, 32'h55, 32'd0, 5'd0, ALUC_ADDU, 5'd6, 1'b1, 1'b1, C_ALU);
      #1;
      chk("loaduse stall_req", {31'd0, stall_req}, 32'd1);
      stall = 1'b1;
      tick();
      chk("loaduse+stall holds valid", {31'd0, ex_valid}, 32'd1);
      chk("loaduse+stall holds rd", {27'd0, ex_rd}, 32'd4);
      chk("loaduse+stall stall_req", {31'd0, stall_req}, 32'd1);
      stall = 1'b0;
      tick();
      chk("loaduse bubble valid", {31'd0, ex_valid}, 32'd0);
      chk("loaduse bubble aluc", {28'd0, alu_aluc}, 32'd0);
      chk("loaduse bubble ctrl", {24'd0, ex_ctrl}, 32'd0);
      chk("loaduse bubble stall_req", {31'd0, stall_req}, 32'd0);
      tick();
      chk("loaduse reload valid", {31'd0, ex_valid}, 32'd1);
      chk("loaduse reload alu_a", alu_a, 32'h44);
      chk("loaduse reload alu_b", alu_b, 32'h55);
      chk("loaduse reload rd", {27'd0, ex_rd}, 32'd6);
      $display("loaduse: alu_a=%h alu_b=%h rd=%0d valid=%b", alu_a, alu_b, ex_rd, ex_valid);

      // Reset while stalled clears the stage
      stall = 1'b1;
      rst   = 1'b1;
      tick();
      chk("rst midstall valid", {31'd0, ex_valid}, 32'd0);
      chk("rst midstall alu_a", alu_a, 32'd0);
      chk("rst midstall ctrl", {24'd0, ex_ctrl}, 32'd0);
      rst   = 1'b0;
      stall = 1'b0;
      $display("rst midstall: alu_a=%h valid=%b", alu_a, ex_valid);

      // Load ADD rs=8 (5), rt=9 (7), then park a harmless ID entry
      set_id(1'b1, 5'd8, 32'd5, 5'd9, 32'd7, 32'd0, 5'd0, ALUC_ADD, 5'd10, 1'b1, 1'b1, C_ALU);
      tick();
      set_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 8'd0);
`ifdef EX_FWD_EN
      set_fwd(5'd8, 1'b1, 32'hAA, 5'd8, 1'b1, 32'hBB);
      #1;
      chk("fwd mem over wb", alu_a, 32'hAA);
      mem_reg_write = 1'b0;
      #1;
      chk("fwd wb only", alu_a, 32'hBB);
      mem_reg_write = 1'b1;
      mem_rd = 5'd9;
      #1;
      chk("fwd rt alu_b", alu_b, 32'hAA);
      chk("fwd rt store", ex_store_data, 32'hAA);
      chk("fwd rs from wb", alu_a, 32'hBB);
      $display("fwd: alu_a=%h alu_b=%h store=%h", alu_a, alu_b, ex_store_data);
      set_id(1'b1, 5'd0, 32'h33, 5'd9, 32'd7, 32'd0, 5'd0, ALUC_ADD, 5'd10, 1'b1, 1'b1, C_ALU);
      set_fwd(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB);
      tick();
      chk("fwd r0 uses latched", alu_a, 32'h33);
      $display("fwd r0: alu_a=%h", alu_a);
`else
      set_fwd(5'd8, 1'b1, 32'hAA, 5'd0, 1'b0, 32'd0);
      #1;
      chk("nofwd latched alu_a", alu_a, 32'd5);
      chk("nofwd idle stall_req", {31'd0, stall_req}, 32'd0);
      id_rs = 5'd8;
      id_uses_rs = 1'b1;
      #1;
      chk("nofwd mem raw stall_req", {31'd0, stall_req}, 32'd1);
      set_fwd(5'd0, 1'b0, 32'd0, 5'd8, 1'b1, 32'hBB);
      #1;
      chk("nofwd wb raw stall_req", {31'd0, stall_req}, 32'd1);
      id_rs = 5'd0;
      wb_rd = 5'd0;
      #1;
      chk("nofwd r0 stall_req", {31'd0, stall_req}, 32'd0);
      $display("nofwd: alu_a=%h stall_req=%b", alu_a, stall_req);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-select stage directly upstream of the ALU in the 54-instruction pipelined CPU. It latches decoded ID fields on each clock and presents `a`, `b` and `aluc` to the ALU. It forwards results from EX/MEM and MEM/WB into those operands. It detects load-use hazards and inserts bubbles for them.

## Interface
- No parameters; all field widths are fixed by the MIPS ISA.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold all latched contents.
- `flush` in 1: replace the next latched entry with a bubble.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_val`, `id_rt_val` in 32 each: register-file read data.
- `id_imm` in 32: immediate, already sign- or zero-extended (LUI uses an unshifted imm; the ALU shifts it).
- `id_shamt` in 5: shift amount.
- `id_aluc` in 4: ALU opcode.
- `id_rs`, `id_rt`, `id_rd` in 5 each: source register numbers and resolved destination register number.
- `id_uses_rs`, `id_uses_rt` in 1 each: the instruction reads that source.
- `id_ctrl` in 8: packed control bits; the bit layout is defined in the package.
- `mem_rd` in 5, `mem_reg_write` in 1, `mem_fwd_val` in 32: EX/MEM forwarding source.
- `wb_rd` in 5, `wb_reg_write` in 1, `wb_val` in 32: MEM/WB forwarding source.
- `stall_req` out 1: tells IF/ID to hold.
- `alu_a`, `alu_b` out 32 each: ALU operands.
- `alu_aluc` out 4: ALU opcode.
- `ex_store_data` out 32: forwarded rt value for stores.
- `ex_rd` out 5, `ex_ctrl` out 8, `ex_valid` out 1: passed downstream to EX/MEM.

## Operation
- The register update priority per edge is `rst` > `flush` > `stall` > load-use bubble > normal load.
  - Bubble: every latched field is zeroed, including `ex_valid` and `ex_ctrl`.
  - `stall`: every field holds its value.
  - Normal load: every field captures its `id_*` input.
- Load-use condition: `stall_req` = `ex_valid` & `ex_ctrl.mem_read` & (`ex_rd` ≠ 0) & ((`ex_rd` = `id_rs` & `id_uses_rs`) | (`ex_rd` = `id_rt` & `id_uses_rt`)).
  - `stall_req` is combinational.
  - At the edge, the stage inserts a bubble unless `stall` is asserted.
- Forwarding is evaluated separately for the latched rs and for the latched rt:
  - If the register number is 0, the latched value is used.
  - Else if `mem_reg_write` is set and `mem_rd` matches, `mem_fwd_val` is used.
  - Else if `wb_reg_write` is set and `wb_rd` matches, `wb_val` is used.
  - Otherwise the latched value is used.
  - EX/MEM always wins over MEM/WB.
- `alu_a` = {27'b0, shamt} if `alu_src_shamt` is set, else the forwarded rs.
- `alu_b` = imm if `alu_src_imm` is set, else the forwarded rt.
- `ex_store_data` is always the forwarded rt.
- `alu_aluc` is the latched aluc. A bubble produces aluc = 4'b0000 (ADDU), so the bubble has no overflow side effect in the ALU.

## Timing
- Latency is 1 cycle: ID inputs at edge N appear in the outputs after edge N.
- The forwarding muxes and `stall_req` are combinational and take effect in the same cycle.
- After reset, every output is 0: `ex_valid`=0, `ex_ctrl`=0, `alu_aluc`=0, `alu_a`=0, `alu_b`=0, `stall_req`=0.
- `rst` or `flush` mid-stall clears the stage at that edge.
- `stall` with `flush` asserted together produces a bubble.
- `stall` with a load-use hazard holds the stage (no bubble), and `stall_req` stays asserted.

## Configuration
- Macro `EX_FWD_EN`.
  - Defined: forwarding operates as described above.
  - Undefined: the forward muxes are removed and the latched values are used directly. `stall_req` then also asserts on any RAW match, with a nonzero rd and the matching `reg_write` set, against EX (`ex_rd`), EX/MEM (`mem_rd`) or MEM/WB (`wb_rd`).

## Structure
- Package `cpu_pkg` holds:
  - aluc constants: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 100x, SLTU 1010, SLT 1011, shifts 11xx;
  - the `id_ctrl` bit indices: alu_src_imm, alu_src_shamt, reg_write, mem_read, mem_write, wb_sel[2:0];
  - the bubble constant.
- One sub-module, `ex_fwd_sel`: the 3-way forward select for a single operand, instantiated twice (rs and rt).

## Test plan
- Reset → all outputs 0. Then load ADD with rs=8 (val 5), rt=9 (val 7) → `alu_a`=5, `alu_b`=7, `alu_aluc`=0010.
- Forwarding priority: latched rs=8; set `mem_rd`=8 with `mem_fwd_val`=0xAA and `wb_rd`=8 with `wb_val`=0xBB, both write enables set → `alu_a`=0xAA. Clear `mem_reg_write` → 0xBB. Use rs=0 with `mem_rd`=0 → latched value.
- Load-use: EX holds LW with rd=4; ID reads rs=4 → `stall_req`=1, next cycle `ex_valid`=0 and `alu_aluc`=0000. Following cycle the instruction loads.
- Simultaneous `stall`=1 and `flush`=1 → the edge produces a bubble. `stall`=1 alone for 3 cycles → outputs constant.
- Shift and immediate select: SLL with shamt=3, rt=0x1 → `alu_a`=3, `alu_b`=0x1. ORI with imm=0xFFFF → `alu_b`=0x0000FFFF.
- Build without `EX_FWD_EN`: `mem_rd` matches `id_rs` with `mem_reg_write`=1 → `stall_req`=1.
